// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding, frame constants and checksum helper for uart_cmd_ctrl.
// Macro UART_CMD_CHKSUM_EN adds the CHK state, the 5-byte frame and the checksum helper.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef UART_CMD_CHKSUM_EN
    localparam int unsigned FRAME_BYTES = 5;
`else
    localparam int unsigned FRAME_BYTES = 4;
`endif

    // Byte-collecting states are numbered by their byte position in the frame.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPC  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
`ifdef UART_CMD_CHKSUM_EN
        CHK  = 3'd4,
`endif
        HOLD = 3'd5
    } state_t;

    localparam state_t LAST_BYTE_ST = state_t'(3'(FRAME_BYTES - 1));

`ifdef UART_CMD_CHKSUM_EN
    function automatic logic chk_ok(input logic [7:0] opc, input logic [7:0] hi,
                                    input logic [7:0] lo, input logic [7:0] chk);
        logic [7:0] sum;
        sum = opc + hi + lo + chk;
        return sum == 8'h00;
    endfunction
`endif

endpackage

// File: rtl/cmd_timer.sv
// cmd_timer: inter-byte watchdog; counts while en, clears on clr, flags the last allowed cycle.
module cmd_timer #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int unsigned   CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles SYNC/OPCODE/DATA_HI/DATA_LO[/CHK] frames from a UART receiver into a
// held command. Define UART_CMD_CHKSUM_EN to require and verify the trailing CHK byte.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic        cmd_vld,
    output logic [7:0]  opcode,
    output logic [15:0] data,
    input  logic        cmd_ack,
    output logic        err
);
    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] data_q, data_d;
    logic        clr_rdy_q, clr_rdy_d;
    logic        err_q, err_d;
    logic        armed_q, armed_d;
    logic        take, in_frame, tmr_clr, tmr_expire, frame_good;

    // armed_q blocks a second capture of the same byte until rx_rdy has been seen low.
    assign in_frame = (state_q != IDLE) && (state_q != HOLD);
    assign take     = rx_rdy && armed_q && (state_q != HOLD);
    assign tmr_clr  = take || !in_frame;

`ifdef UART_CMD_CHKSUM_EN
    assign frame_good = chk_ok(opcode_q, data_q[15:8], data_q[7:0], rx_data);
`else
    assign frame_good = 1'b1;
`endif

    cmd_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (in_frame),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        data_d    = data_q;
        err_d     = 1'b0;
        clr_rdy_d = take;
        armed_d   = take ? 1'b0 : (armed_q || !rx_rdy);

        case (state_q)
            IDLE: begin
                if (take && (rx_data == SYNC_BYTE)) begin
                    state_d = OPC;
                end
            end
            HOLD: begin
                if (cmd_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (take) begin
                    if (state_q == OPC) opcode_d = rx_data;
                    if (state_q == DHI) data_d[15:8] = rx_data;
                    if (state_q == DLO) data_d[7:0] = rx_data;
                    if (state_q == LAST_BYTE_ST) begin
                        state_d = frame_good ? HOLD : IDLE;
                        err_d   = !frame_good;
                    end else begin
                        state_d = state_t'(state_q + 3'd1);
                    end
                end else if (tmr_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= 8'h00;
            data_q    <= 16'h0000;
            clr_rdy_q <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            data_q    <= data_d;
            clr_rdy_q <= clr_rdy_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
        end
    end

    assign clr_rdy = clr_rdy_q;
    assign err     = err_q;
    assign opcode  = opcode_q;
    assign data    = data_q;
    assign cmd_vld = (state_q == HOLD);

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start byte.
REQ-002 Parameter TIMEOUT_CYC, default 4096: maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_rdy  input  1  byte-available flag from the UART receiver.
REQ-006 rx_data  input  8  received byte; valid while rx_rdy=1.
REQ-007 clr_rdy  output  1  one-cycle pulse that consumes the current receiver byte.
REQ-008 cmd_vld  output  1  assembled command is available; held until acknowledged.
REQ-009 opcode  output  8  command opcode; stable while cmd_vld=1.
REQ-010 data  output  16  command operand, high byte first on the wire; stable while cmd_vld=1.
REQ-011 cmd_ack  input  1  consumer accepts the command.
REQ-012 err  output  1  one-cycle pulse on a frame error (timeout or checksum).

Function
REQ-013 Frame format: SYNC, OPCODE, DATA_HI, DATA_LO, then CHK when enabled.
REQ-014 States: IDLE, OPC, DHI, DLO, CHK, HOLD. CHK exists only when the macro is defined.
REQ-015 In each of IDLE/OPC/DHI/DLO/CHK, when rx_rdy=1 the block captures rx_data, pulses clr_rdy for exactly one cycle, and advances on the next edge.
REQ-016 A byte is consumed at most once: after a capture, clr_rdy stays 0 until rx_rdy has been observed 0.
REQ-017 In IDLE, a non-SYNC byte is consumed and discarded; the state stays IDLE and err is not pulsed.
REQ-018 The frame transitions are: IDLE→OPC on SYNC, OPC→DHI, DHI→DLO, then DLO→CHK (macro defined) or DLO→HOLD (macro undefined).
REQ-019 cmd_vld rises in the cycle after the final byte is captured.
REQ-020 In HOLD, cmd_vld=1 and rx_rdy is ignored: clr_rdy stays 0, which back-pressures the receiver.
REQ-021 In HOLD, cmd_ack=1 clears cmd_vld on the next edge and returns the block to IDLE.
REQ-022 cmd_ack outside HOLD is ignored.
REQ-023 The inter-byte timer clears on every capture and counts while in OPC/DHI/DLO/CHK. It does not count in IDLE or HOLD.
REQ-024 When the timer reaches TIMEOUT_CYC-1, err pulses for one cycle and the state returns to IDLE; the partial frame is discarded.
REQ-025 If rx_rdy=1 in the same cycle the timeout fires, the byte is captured and the timeout is suppressed.
REQ-026 opcode and data update only on the capture of their own bytes. They hold their last values after an error.

Reset
REQ-027 Asynchronous rst_n=0 forces: state IDLE, timer 0, clr_rdy=0, cmd_vld=0, err=0, opcode=8'h00, data=16'h0000.
REQ-028 Reset mid-frame or in HOLD abandons the command without an err pulse.

Configuration
REQ-029 With UART_CMD_CHKSUM_EN defined:
- CHK byte is required.
- Checksum is the 8-bit sum, modulo 256, of OPCODE+DATA_HI+DATA_LO+CHK, and must equal 8'h00.
- Match → HOLD.
- Mismatch → err pulse, return to IDLE, cmd_vld never asserted.
REQ-030 Without UART_CMD_CHKSUM_EN: 4-byte frame, no CHK state, and no checksum logic is synthesized.

Structure
REQ-031 Package uart_cmd_pkg holds:
- state_t enum
- SYNC_BYTE default constant
- frame byte-count constants
REQ-032 The inter-byte timer is sub-module cmd_timer, with inputs clr and en and a 1-cycle output expire. Its counter width is $clog2(TIMEOUT_CYC).

Verification
REQ-033 Send A5,12,34,56 (macro off) → cmd_vld=1 with opcode=8'h12, data=16'h3456. The vector holds until cmd_ack, then the block returns to IDLE.
REQ-034 Send 00,FF,A5,01,00,02 → the first two bytes are consumed with no err. Command opcode=8'h01, data=16'h0002.
REQ-035 Send A5,12 then idle 4096 cycles → a single err pulse, state IDLE, cmd_vld stays 0.
REQ-036 Macro on, send A5,10,20,30,A0 → command accepted (sum 8'h00). Send A5,10,20,30,A1 → err pulse, no cmd_vld.
REQ-037 Hold cmd_ack=0 after a command and present a new rx_rdy → clr_rdy stays 0. After cmd_ack, the pending byte is consumed in IDLE.
REQ-038 Assert rst_n=0 after the DATA_HI byte → all outputs at reset values, no err. A following full frame decodes correctly.
